// File: rtl/ex_muldiv_pkg.sv
// Shared opcode constants, RV32M funct3 encoding and FSM state type for the EX-stage
// multiply/divide unit.
package ex_muldiv_pkg;

  localparam logic [6:0] OPC_OP    = 7'b0110011;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } muldiv_op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BUSY,
    ST_DONE
  } muldiv_state_e;

endpackage

// File: rtl/ex_muldiv_if.sv
// EX-stage bundle between the ID/EX register / writeback mux and the mul/div unit.
interface ex_muldiv_if;

  logic        i_insn_vld;
  logic [31:0] i_instr;
  logic [31:0] i_rs1_data;
  logic [31:0] i_rs2_data;
  logic        i_flush;
  logic        o_stall;
  logic        o_busy;
  logic        o_result_vld;
  logic [31:0] o_result;

  modport slave (
    input  i_insn_vld, i_instr, i_rs1_data, i_rs2_data, i_flush,
    output o_stall, o_busy, o_result_vld, o_result
  );

  modport master (
    output i_insn_vld, i_instr, i_rs1_data, i_rs2_data, i_flush,
    input  o_stall, o_busy, o_result_vld, o_result
  );

endinterface

// File: rtl/ex_muldiv_div_core.sv
// Restoring divider datapath on unsigned magnitudes: start loads the operands,
// each step retires one quotient bit, MSB first.
module ex_muldiv_div_core (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        start_i,
  input  logic        step_i,
  input  logic [31:0] dividend_i,
  input  logic [31:0] divisor_i,
  output logic [31:0] quotient_o,
  output logic [31:0] remainder_o
);

  logic [31:0] rem_q, rem_d;
  logic [31:0] quo_q, quo_d;
  logic [31:0] dvs_q;
  logic [32:0] shifted;
  logic [32:0] diff;

  // Bit 32 of the difference is set exactly when the trial subtraction borrows.
  always_comb begin
    shifted = {rem_q, quo_q[31]};
    diff    = shifted - {1'b0, dvs_q};
    if (!diff[32]) begin
      rem_d = diff[31:0];
      quo_d = {quo_q[30:0], 1'b1};
    end else begin
      rem_d = shifted[31:0];
      quo_d = {quo_q[30:0], 1'b0};
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rem_q <= '0;
      quo_q <= '0;
      dvs_q <= '0;
    end else if (start_i) begin
      rem_q <= '0;
      quo_q <= dividend_i;
      dvs_q <= divisor_i;
    end else if (step_i) begin
      rem_q <= rem_d;
      quo_q <= quo_d;
    end
  end

  assign quotient_o  = quo_q;
  assign remainder_o = rem_q;

endmodule

// File: rtl/ex_muldiv.sv
// RV32M multiply/divide unit for the EX stage; holds the pipeline front while busy.
// Define MULDIV_FAST_MUL_EN for a single-cycle registered multiply (divide stays iterative).
module ex_muldiv
  import ex_muldiv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input logic        i_clk,
  input logic        i_rst_n,
  ex_muldiv_if.slave bus
);

  muldiv_state_e     state_q, state_d;
  muldiv_op_e        opIn, op_q;
  logic [4:0]        cnt_q;
  logic              isM, isDivIn, aSigned, bSigned, aNeg, bNeg, divZero, divOvf;
  logic [XLEN-1:0]   opA, opB, aAbs, bAbs, specialRes, specialRes_q, mcand_q;
  logic              negQuo_q, negRem_q, special_q, startOp, stepOp;
  logic [2*XLEN-1:0] prod_q, prodFix;
  logic [XLEN:0]     mulSum;
  logic [XLEN-1:0]   quo, rem, quoFix, remFix;
  logic              unused_instr;

  assign opA          = bus.i_rs1_data;
  assign opB          = bus.i_rs2_data;
  assign unused_instr = ^{bus.i_instr[24:15], bus.i_instr[11:7]};

  // Decode and operand conditioning for the instruction currently sitting in EX.
  always_comb begin
    opIn    = muldiv_op_e'(bus.i_instr[14:12]);
    isM     = bus.i_insn_vld && (bus.i_instr[6:0] == OPC_OP) && (bus.i_instr[31:25] == F7_MULDIV);
    isDivIn = opIn[2];
    if (isDivIn) begin
      aSigned = ~opIn[0];
      bSigned = ~opIn[0];
    end else begin
      aSigned = (opIn != OP_MULHU);
      bSigned = (opIn == OP_MUL) || (opIn == OP_MULH);
    end
    aNeg       = aSigned & opA[XLEN-1];
    bNeg       = bSigned & opB[XLEN-1];
    aAbs       = aNeg ? -opA : opA;
    bAbs       = bNeg ? -opB : opB;
    divZero    = isDivIn && (opB == '0);
    divOvf     = isDivIn && aSigned && (opA == {1'b1, {(XLEN-1){1'b0}}}) && (opB == '1);
    specialRes = divZero ? (opIn[1] ? opA : '1)
                         : (opIn[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}});
  end

`ifdef MULDIV_FAST_MUL_EN
  logic signed [2*XLEN+1:0] fastProd;
  logic                     unused_fast;
  assign fastProd    = $signed({aNeg, opA}) * $signed({bNeg, opB});
  assign unused_fast = ^fastProd[2*XLEN+1:2*XLEN];
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (isM) begin
          if (divZero || divOvf) state_d = ST_DONE;
`ifdef MULDIV_FAST_MUL_EN
          else if (!isDivIn)     state_d = ST_DONE;
`endif
          else                   state_d = ST_BUSY;
        end
      end
      ST_BUSY: if (cnt_q == 5'd31) state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (bus.i_flush) state_d = ST_IDLE;
  end

  // Unsigned shift-add multiply: the multiplier sits in the low half of prod_q.
  assign mulSum = {1'b0, prod_q[2*XLEN-1:XLEN]} + (prod_q[0] ? {1'b0, mcand_q} : '0);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      op_q         <= OP_MUL;
      cnt_q        <= '0;
      negQuo_q     <= 1'b0;
      negRem_q     <= 1'b0;
      special_q    <= 1'b0;
      specialRes_q <= '0;
      mcand_q      <= '0;
      prod_q       <= '0;
    end else if (startOp) begin
      op_q         <= opIn;
      cnt_q        <= '0;
      negQuo_q     <= aNeg ^ bNeg;
      negRem_q     <= aNeg;
      special_q    <= divZero | divOvf;
      specialRes_q <= specialRes;
      mcand_q      <= aAbs;
      prod_q       <= {{XLEN{1'b0}}, bAbs};
`ifdef MULDIV_FAST_MUL_EN
      if (!isDivIn) begin
        prod_q   <= fastProd[2*XLEN-1:0];
        negQuo_q <= 1'b0;
      end
`endif
    end else if (stepOp) begin
      cnt_q <= cnt_q + 5'd1;
      if (!op_q[2]) prod_q <= {mulSum, prod_q[XLEN-1:1]};
    end
  end

  ex_muldiv_div_core u_div (
    .clk_i       (i_clk),
    .rst_ni      (i_rst_n),
    .start_i     (startOp & isDivIn),
    .step_i      (stepOp & op_q[2]),
    .dividend_i  (aAbs),
    .divisor_i   (bAbs),
    .quotient_o  (quo),
    .remainder_o (rem)
  );

  // Stall is forced low by reset and by flush so the pipeline never freezes on a dead op.
  always_comb begin
    startOp          = (state_q == ST_IDLE) && isM && !bus.i_flush;
    stepOp           = (state_q == ST_BUSY) && !bus.i_flush;
    bus.o_stall      = i_rst_n && !bus.i_flush &&
                       (((state_q == ST_IDLE) && isM) || (state_q == ST_BUSY));
    bus.o_busy       = (state_q != ST_IDLE);
    bus.o_result_vld = (state_q == ST_DONE) && !bus.i_flush;
    prodFix          = negQuo_q ? -prod_q : prod_q;
    quoFix           = negQuo_q ? -quo : quo;
    remFix           = negRem_q ? -rem : rem;
    bus.o_result     = '0;
    if (state_q == ST_DONE) begin
      if (special_q)      bus.o_result = specialRes_q;
      else if (op_q[2])   bus.o_result = op_q[1] ? remFix : quoFix;
      else if (op_q == OP_MUL) bus.o_result = prodFix[XLEN-1:0];
      else                bus.o_result = prodFix[2*XLEN-1:XLEN];
    end
  end

endmodule
